// File: rtl/ms_timer_pkg.sv
// ms_timer_pkg
//   Shared types, default constants and the round-robin search helper for
//   the millisecond timeout scheduler.
package ms_timer_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  localparam int MS_DIV_DEFAULT   = 1000;
  localparam int MS_CNT_W_DEFAULT = 10;
  localparam int MS_MAX_CH        = 16;

  // First set bit of req[n-1:0], searching upward from ptr with wrap-around.
  // Returns 0 when nothing is requested. Callers keep ptr < n.
  function automatic logic [3:0] rr_find_first(input logic [15:0] req,
                                               input logic [3:0]  ptr,
                                               input int          n);
    logic       found;
    logic [3:0] idx;
    int         j;
    rr_find_first = '0;
    found         = 1'b0;
    for (int k = 0; k < MS_MAX_CH; k++) begin
      if (k < n && !found) begin
        j   = (int'(ptr) + k) % n;
        idx = 4'(j);
        if (req[idx]) begin
          rr_find_first = idx;
          found         = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen
//   Prescaler producing a one-cycle millisecond tick every DIV sb_clk cycles.
//   Ports:
//     i_sb_clk  - sideband clock
//     i_rst     - synchronous active-low reset
//     o_ms_tick - high for one cycle when the prescaler sits at DIV-1
module ms_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic i_sb_clk,
  input  logic i_rst,
  output logic o_ms_tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap    = (r_cnt == CW'(DIV - 1));
  assign o_ms_tick = w_wrap;

  always_ff @(posedge i_sb_clk) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ms_timer_sched.sv
// ms_timer_sched
//   Multi-channel millisecond timeout scheduler. One shared ms tick drives
//   NUM_CH down-counting channels; expiries are reported one at a time on a
//   valid/ready event port with round-robin arbitration.
//   Ports:
//     i_sb_clk     - sideband clock (only clock)
//     i_rst        - synchronous active-low reset
//     i_start      - per-channel load strobe
//     i_load_ms    - per-channel load value, channel i at [i*CNT_W +: CNT_W]
//     i_cancel     - per-channel abort strobe (start wins if both)
//     o_busy       - channel is counting
//     o_ms_tick    - one-cycle pulse every DIV cycles
//     o_evt_valid  - an expiry event is presented
//     o_evt_ch     - index of the presented channel
//     i_evt_ready  - consumer accepts the event
//
//   Channel FSM:
//     state   | meaning
//     CH_IDLE | not counting (pend may hold an unacknowledged expiry)
//     CH_RUN  | counting down remain on every ms tick
module ms_timer_sched
  import ms_timer_pkg::*;
#(
  parameter int DIV    = MS_DIV_DEFAULT,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = MS_CNT_W_DEFAULT,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic                    i_sb_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH-1:0]       i_start,
  input  logic [NUM_CH*CNT_W-1:0] i_load_ms,
  input  logic [NUM_CH-1:0]       i_cancel,
  output logic [NUM_CH-1:0]       o_busy,
  output logic                    o_ms_tick,
  output logic                    o_evt_valid,
  output logic [CH_W-1:0]         o_evt_ch,
  input  logic                    i_evt_ready
);

  logic              w_tick;
  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_pend_nxt;
  logic              w_evt_valid;
  logic [CH_W-1:0]   w_evt_ch;
  logic [CH_W-1:0]   w_rr_ch;
  logic              w_accept;
  logic [CH_W-1:0]   r_ptr;
  logic              r_lock_vld;
  logic [CH_W-1:0]   r_lock_ch;

  ms_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .i_sb_clk (i_sb_clk),
    .i_rst    (i_rst),
    .o_ms_tick(w_tick)
  );

  assign o_ms_tick = w_tick;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_state_e        r_state;
    ch_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] w_remain_nxt;
    logic [CNT_W-1:0] w_load;
    logic             r_pend;
    logic             w_pend_set;
    logic             w_pend_clr;
    logic             w_acc;

    assign w_load = i_load_ms[gi*CNT_W +: CNT_W];
    assign w_acc  = w_accept && (w_evt_ch == CH_W'(gi));

    always_comb begin
      w_state_nxt  = r_state;
      w_remain_nxt = r_remain;
      w_pend_set   = 1'b0;
      w_pend_clr   = 1'b0;
      if (i_start[gi]) begin
        // A load masks any tick on the same edge.
        if (w_load == '0) begin
          w_state_nxt = CH_IDLE;
          w_pend_set  = 1'b1;
        end else begin
          w_state_nxt  = CH_RUN;
          w_remain_nxt = w_load;
          w_pend_clr   = 1'b1;
        end
      end else if (i_cancel[gi]) begin
        w_state_nxt = CH_IDLE;
        w_pend_clr  = 1'b1;
      end else if (r_state == CH_RUN && w_tick) begin
        if (r_remain > CNT_W'(1)) begin
          w_remain_nxt = r_remain - 1'b1;
        end else begin
          w_state_nxt = CH_IDLE;
          w_pend_set  = 1'b1;
        end
      end
    end

    // A new expiry beats the acknowledge of the previous one.
    assign w_pend_nxt[gi] = w_pend_set | (r_pend & ~w_pend_clr & ~w_acc);

    always_ff @(posedge i_sb_clk) begin
      if (!i_rst) begin
        r_state  <= CH_IDLE;
        r_remain <= '0;
        r_pend   <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_remain <= w_remain_nxt;
        r_pend   <= w_pend_nxt[gi];
      end
    end

    assign w_pend[gi] = r_pend;
    assign o_busy[gi] = (r_state == CH_RUN);
  end

  assign w_evt_valid = |w_pend;
  assign w_rr_ch     = CH_W'(rr_find_first(16'(w_pend), 4'(r_ptr), NUM_CH));
  // A stalled event stays on the port even if a channel nearer the pointer
  // expires meanwhile; the lock drops once its pend is withdrawn.
  assign w_evt_ch    = r_lock_vld ? r_lock_ch : w_rr_ch;
  assign w_accept    = w_evt_valid && i_evt_ready;

  assign o_evt_valid = w_evt_valid;
  assign o_evt_ch    = w_evt_valid ? w_evt_ch : '0;

  always_ff @(posedge i_sb_clk) begin
    if (!i_rst) begin
      r_ptr      <= '0;
      r_lock_vld <= 1'b0;
      r_lock_ch  <= '0;
    end else begin
      if (w_accept) begin
        if (w_evt_ch == CH_W'(NUM_CH - 1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_evt_ch + 1'b1;
        end
      end
      r_lock_vld <= w_evt_valid && !i_evt_ready && w_pend_nxt[w_evt_ch];
      r_lock_ch  <= w_evt_ch;
    end
  end

endmodule

// File: tb/tb_ms_timer_sched.sv
module tb_ms_timer_sched;
  localparam int DIV = 10;
  localparam int N   = 4;
  localparam int CW  = 10;
  localparam int CHW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  start = '0;
  logic [N-1:0]  cancel = '0;
  logic [N*CW-1:0] load = '0;
  logic          ready = 1'b0;
  logic [N-1:0]  busy;
  logic          tick;
  logic          evt_valid;
  logic [CHW-1:0] evt_ch;

  ms_timer_sched #(.DIV(DIV), .NUM_CH(N), .CNT_W(CW)) dut (
    .i_sb_clk   (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_load_ms  (load),
    .i_cancel   (cancel),
    .o_busy     (busy),
    .o_ms_tick  (tick),
    .o_evt_valid(evt_valid),
    .o_evt_ch   (evt_ch),
    .i_evt_ready(ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: absolute tick numbering, each running channel expires
  // when the tick count reaches its target.
  int m_cyc;
  int m_nt;
  bit m_run [N];
  int m_tgt [N];
  bit m_pend[N];
  int m_ptr;
  bit m_hold;
  int m_hold_ch;

  function automatic bit m_any();
    bit a = 1'b0;
    for (int c = 0; c < N; c++) a |= m_pend[c];
    return a;
  endfunction

  function automatic int m_exp_ch();
    if (m_hold) return m_hold_ch;
    for (int k = 0; k < N; k++) begin
      if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic int m_busy();
    int b = 0;
    for (int c = 0; c < N; c++) if (m_run[c]) b |= (1 << c);
    return b;
  endfunction

  task automatic model_step();
    bit tk, v, acc, set, clr;
    int ech, l;
    if (!rst) begin
      m_cyc = 0; m_nt = 0; m_ptr = 0; m_hold = 1'b0; m_hold_ch = 0;
      for (int c = 0; c < N; c++) begin
        m_run[c] = 1'b0; m_pend[c] = 1'b0; m_tgt[c] = 0;
      end
    end else begin
      tk  = (m_cyc % DIV == DIV - 1);
      v   = m_any();
      ech = m_exp_ch();
      acc = v && ready;
      if (tk) m_nt++;
      for (int c = 0; c < N; c++) begin
        set = 1'b0; clr = 1'b0;
        l = int'(load[c*CW +: CW]);
        if (start[c]) begin
          if (l == 0) begin m_run[c] = 1'b0; set = 1'b1; end
          else begin m_run[c] = 1'b1; m_tgt[c] = m_nt + l; clr = 1'b1; end
        end else if (cancel[c]) begin
          m_run[c] = 1'b0; clr = 1'b1;
        end else if (m_run[c] && tk && m_nt == m_tgt[c]) begin
          m_run[c] = 1'b0; set = 1'b1;
        end
        if (set) m_pend[c] = 1'b1;
        else if (clr || (acc && ech == c)) m_pend[c] = 1'b0;
      end
      if (acc) m_ptr = (ech + 1) % N;
      m_hold    = v && !ready && m_pend[ech];
      m_hold_ch = ech;
      m_cyc++;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", int'(busy), m_busy());
      chk("ms_tick", int'(tick), int'(m_cyc % DIV == DIV - 1));
      chk("evt_valid", int'(evt_valid), int'(m_any()));
      if (m_any()) chk("evt_ch", int'(evt_ch), m_exp_ch());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0; start = '0; cancel = '0; ready = 1'b0;
    cyc(n);
    rst = 1'b1;
  endtask

  task automatic wait_tick_seen();
    int k = 0;
    while (!tick && k < 5 * DIV) begin cyc(1); k++; end
    if (!tick) chk("tick_wait_timeout", int'(tick), 1);
  endtask

  task automatic set_load(input int c, input int l);
    load[c*CW +: CW] = CW'(l);
  endtask

  task automatic pulse_start(input int c, input int l);
    set_load(c, l);
    start[c] = 1'b1;
    cyc(1);
    start = '0;
  endtask

  task automatic count_until_valid(output int n, input int max);
    n = 0;
    while (!evt_valid && n < max) begin cyc(1); n++; end
  endtask

  int n, nt, vcnt;

  initial begin
    // Reset and first tick position
    do_reset(5);
    cmp_en = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_ch", int'(evt_ch), 0);
    n = 0;
    while (!tick && n < 50) begin cyc(1); n++; end
    chk("first_tick_cycle", n, 9);

    // Single timeout, ch1 L=3, two cycles after a tick
    cyc(2);
    set_load(1, 3); start[1] = 1'b1;
    cyc(1); start = '0;
    chk("single_busy", int'(busy[1]), 1);
    count_until_valid(n, 100);
    chk("single_latency", n + 1, 29);
    chk("single_ch", int'(evt_ch), 1);
    chk("single_busy_done", int'(busy[1]), 0);
    ready = 1'b1; cyc(1); ready = 1'b0;
    chk("single_acked", int'(evt_valid), 0);

    // Simultaneous expiry on 0,2,3
    do_reset(3);
    wait_tick_seen(); cyc(1);
    set_load(0, 2); set_load(2, 2); set_load(3, 2);
    start = 4'b1101; cyc(1); start = '0;
    count_until_valid(n, 100);
    chk("sim_valid", int'(evt_valid), 1);
    cyc(5);
    chk("sim_hold_ch", int'(evt_ch), 0);
    ready = 1'b1;
    chk("sim_ch_a", int'(evt_ch), 0); cyc(1);
    chk("sim_ch_b", int'(evt_ch), 2); cyc(1);
    chk("sim_ch_c", int'(evt_ch), 3); cyc(1);
    chk("sim_drained", int'(evt_valid), 0);
    ready = 1'b0;

    // Cancel then restart
    do_reset(3);
    pulse_start(2, 5);
    wait_tick_seen(); cyc(1);
    wait_tick_seen(); cyc(1);
    cancel[2] = 1'b1; cyc(1); cancel = '0;
    chk("cancel_busy", int'(busy[2]), 0);
    vcnt = 0;
    repeat (60) begin if (evt_valid) vcnt++; cyc(1); end
    chk("cancel_no_evt", vcnt, 0);
    pulse_start(0, 4);
    repeat (3) begin wait_tick_seen(); cyc(1); end
    pulse_start(0, 2);
    n = 0; nt = 0;
    while (!evt_valid && n < 60) begin if (tick) nt++; cyc(1); n++; end
    chk("restart_ticks", nt, 2);
    chk("restart_ch", int'(evt_ch), 0);
    ready = 1'b1; cyc(1); ready = 1'b0;

    // Immediate expiry and collisions
    do_reset(3);
    pulse_start(3, 0);
    chk("imm_valid", int'(evt_valid), 1);
    chk("imm_ch", int'(evt_ch), 3);
    ready = 1'b1; cyc(1); ready = 1'b0;
    wait_tick_seen();
    set_load(1, 1); start[1] = 1'b1; cyc(1); start = '0;
    chk("coll_busy", int'(busy[1]), 1);
    chk("coll_no_evt", int'(evt_valid), 0);
    count_until_valid(n, 50);
    chk("coll_latency", n, 10);
    chk("coll_ch", int'(evt_ch), 1);
    ready = 1'b1; cyc(1); ready = 1'b0;
    set_load(2, 3); start[2] = 1'b1; cancel[2] = 1'b1;
    cyc(1); start = '0; cancel = '0;
    chk("start_cancel_busy", int'(busy[2]), 1);
    cancel[2] = 1'b1; cyc(1); cancel = '0;

    // Reset during activity
    do_reset(3);
    set_load(0, 5); set_load(1, 6); set_load(3, 0);
    start = 4'b1011; cyc(1); start = '0;
    chk("mid_busy_pre", int'(busy), 3);
    chk("mid_valid_pre", int'(evt_valid), 1);
    rst = 1'b0; cyc(1);
    chk("mid_busy", int'(busy), 0);
    chk("mid_valid", int'(evt_valid), 0);
    rst = 1'b1;
    vcnt = 0;
    repeat (50) begin if (evt_valid || busy != 0) vcnt++; cyc(1); end
    chk("mid_quiet", vcnt, 0);

    // Random traffic against the model
    do_reset(2);
    repeat (3000) begin
      for (int c = 0; c < N; c++) begin
        int r;
        r = int'($urandom_range(0, 99));
        start[c]  = (r < 4);
        cancel[c] = (r >= 4 && r < 6) || (r == 0);
        set_load(c, int'($urandom_range(0, 4)));
      end
      ready = ($urandom_range(0, 9) < 6);
      rst   = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    start = '0; cancel = '0; ready = 1'b0; rst = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
